// File: rtl/friscv_pump_scheduler_pkg.sv
// friscv_pkg: state codes and juice-select constants shared by the pump scheduler.
package friscv_pkg;
    typedef enum logic [3:0] {
        DESLIGADO   = 4'b0000,
        OCIOSO      = 4'b0001,
        ARBITRA     = 4'b0010,
        ESPERA_COPO = 4'b0011,
        BOMBEANDO   = 4'b0100,
        PAUSA       = 4'b0101,
        CONCLUI     = 4'b0110,
        ERRO        = 4'b0111
    } estado_t;
    localparam logic [3:0] DB_ILEGAL = 4'b1110;
    localparam logic [1:0] SUCO_1 = 2'd1;
    localparam logic [1:0] SUCO_2 = 2'd2;
    function automatic logic estado_valido(input logic [3:0] e);
        return e <= 4'd7;
    endfunction
endpackage

// File: rtl/friscv_pump_scheduler_if.sv
// friscv_pump_scheduler_if: front-panel inputs and pump/status outputs of the scheduler.
interface friscv_pump_scheduler_if;
    logic       habilita;
    logic       req_suco_1;
    logic       req_suco_2;
    logic       copo_posicionado;
    logic       cancela;
    logic       ativa_bomba_1;
    logic       ativa_bomba_2;
    logic       pendente_1;
    logic       pendente_2;
    logic       ocupado;
    logic       erro_copo;
    logic       fim_servico;
    logic [3:0] db_estado;
    modport master (
        output habilita, req_suco_1, req_suco_2, copo_posicionado, cancela,
        input  ativa_bomba_1, ativa_bomba_2, pendente_1, pendente_2, ocupado, erro_copo, fim_servico, db_estado
    );
    modport slave (
        input  habilita, req_suco_1, req_suco_2, copo_posicionado, cancela,
        output ativa_bomba_1, ativa_bomba_2, pendente_1, pendente_2, ocupado, erro_copo, fim_servico, db_estado
    );
endinterface

// File: rtl/friscv_seg_timer.sv
// friscv_seg_timer: prescaled seconds counter; fim rises in the cycle whose count completes the limit.
module friscv_seg_timer #(
    parameter int TICKS_SEG = 50_000_000,
    parameter int SEG_W     = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             conta,
    input  logic             zera,
    input  logic [SEG_W-1:0] limite,
    output logic             fim
);
    localparam int PW = $clog2(TICKS_SEG) + 1;
    logic [PW-1:0]    presc;
    logic [SEG_W-1:0] segs;
    logic             vira;
    logic             cheio;
    assign vira  = presc == PW'(TICKS_SEG - 1);
    assign cheio = segs >= limite;
    // Look-ahead so the owner leaves its state after exactly limite*TICKS_SEG counting cycles.
    assign fim   = cheio || (conta && vira && segs == limite - 1'b1);
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            presc <= '0;
            segs  <= '0;
        end else if (zera) begin
            presc <= '0;
            segs  <= '0;
        end else if (conta && !cheio) begin
            presc <= vira ? '0 : presc + 1'b1;
            segs  <= segs + SEG_W'(vira);
        end
    end
endmodule

// File: rtl/friscv_pump_scheduler.sv
// friscv_pump_scheduler: round-robin sharing of the pump timer between two juice requesters,
// gated on cup presence with pause/resume and cup-timeout error.
module friscv_pump_scheduler
    import friscv_pkg::*;
#(
    parameter int TICKS_SEG = 50_000_000,
    parameter int T_SUCO    = 5,
    parameter int T_TIMEOUT = 10
) (
    input logic                    clock,
    input logic                    reset,
    friscv_pump_scheduler_if.slave bus
);
    localparam int SEG_W = $clog2(T_SUCO + T_TIMEOUT + 1) + 1;
    estado_t    estado, estado_n;
    logic [1:0] sel, ultimo_servido, escolha;
    logic       pend_1, pend_2, ant_1, ant_2, sobe_1, sobe_2;
    logic       fim_bomba, fim_espera, espera_copo;
    assign sobe_1 = bus.req_suco_1 && !ant_1;
    assign sobe_2 = bus.req_suco_2 && !ant_2;
    assign escolha = (pend_1 && (!pend_2 || ultimo_servido == SUCO_2)) ? SUCO_1 : SUCO_2;
    assign espera_copo = estado == ESPERA_COPO || estado == PAUSA;
    friscv_seg_timer #(.TICKS_SEG(TICKS_SEG), .SEG_W(SEG_W)) u_bomba (
        .clock (clock),
        .reset (reset),
        .conta (estado == BOMBEANDO),
        .zera  (estado == ARBITRA),
        .limite(SEG_W'(T_SUCO)),
        .fim   (fim_bomba)
    );
    friscv_seg_timer #(.TICKS_SEG(TICKS_SEG), .SEG_W(SEG_W)) u_espera (
        .clock (clock),
        .reset (reset),
        .conta (espera_copo),
        .zera  (estado == ARBITRA || estado == BOMBEANDO),
        .limite(SEG_W'(T_TIMEOUT)),
        .fim   (fim_espera)
    );
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= DESLIGADO;
        else estado <= estado_n;
    end
    always_comb begin
        estado_n = estado;
        if (!bus.habilita) estado_n = DESLIGADO;
        else begin
            case (estado)
                DESLIGADO:         estado_n = OCIOSO;
                OCIOSO:            estado_n = (pend_1 || pend_2) ? ARBITRA : OCIOSO;
                ARBITRA:           estado_n = bus.cancela ? OCIOSO : ESPERA_COPO;
                ESPERA_COPO, PAUSA: estado_n = bus.cancela ? OCIOSO : bus.copo_posicionado ? BOMBEANDO :
                                              fim_espera ? ERRO : estado;
                // Completion outranks cup removal in the same cycle.
                BOMBEANDO:         estado_n = bus.cancela ? OCIOSO : fim_bomba ? CONCLUI :
                                              !bus.copo_posicionado ? PAUSA : BOMBEANDO;
                CONCLUI:           estado_n = OCIOSO;
                ERRO:              estado_n = bus.cancela ? OCIOSO : ERRO;
                default:           estado_n = OCIOSO;
            endcase
        end
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sel            <= SUCO_1;
            ultimo_servido <= SUCO_2;
            pend_1         <= 1'b0;
            pend_2         <= 1'b0;
            ant_1          <= 1'b0;
            ant_2          <= 1'b0;
        end else begin
            ant_1 <= bus.req_suco_1;
            ant_2 <= bus.req_suco_2;
            if (estado == ARBITRA) sel <= escolha;
            if (estado == CONCLUI) ultimo_servido <= sel;
            // A new edge beats the arbitration clear, leaving a queued repeat.
            pend_1 <= (!bus.habilita || estado == DESLIGADO) ? 1'b0 : sobe_1 ? 1'b1 :
                      (estado == ARBITRA && escolha == SUCO_1) ? 1'b0 : pend_1;
            pend_2 <= (!bus.habilita || estado == DESLIGADO) ? 1'b0 : sobe_2 ? 1'b1 :
                      (estado == ARBITRA && escolha == SUCO_2) ? 1'b0 : pend_2;
        end
    end
    assign bus.ativa_bomba_1 = estado == BOMBEANDO && sel == SUCO_1;
    assign bus.ativa_bomba_2 = estado == BOMBEANDO && sel == SUCO_2;
    assign bus.pendente_1    = pend_1;
    assign bus.pendente_2    = pend_2;
    assign bus.ocupado       = estado != OCIOSO && estado != DESLIGADO;
    assign bus.erro_copo     = estado == ERRO;
    assign bus.fim_servico   = estado == CONCLUI;
    assign bus.db_estado     = estado_valido(estado) ? estado : DB_ILEGAL;
endmodule
